// File: rtl/taus_stream_checker_pkg.sv
// rtl/taus_stream_checker_pkg.sv - taus88 constants and checker state encoding
package taus_stream_checker_pkg;

   localparam logic [31:0] TAUS_S1_XOR = 32'h10850089;
   localparam logic [31:0] TAUS_S2_XOR = 32'h89305309;
   localparam logic [31:0] TAUS_MASK0  = 32'hFFFFFFFE;
   localparam logic [31:0] TAUS_MASK1  = 32'hFFFFFFF8;
   localparam logic [31:0] TAUS_MASK2  = 32'hFFFFFFF0;
   localparam logic [31:0] TAUS_MIN0   = 32'd2;
   localparam logic [31:0] TAUS_MIN1   = 32'd8;
   localparam logic [31:0] TAUS_MIN2   = 32'd16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_BAD  = 2'd2
   } state_t;

endpackage

// File: rtl/taus_stream_checker_if.sv
// rtl/taus_stream_checker_if.sv - uniform-sample bus between URNG and consumer
interface taus_stream_checker_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/taus_stream_checker_step.sv
// rtl/taus_stream_checker_step.sv - combinational taus88 state step and combined output
module taus88_step
   import taus_stream_checker_pkg::*;
(
   input  logic [31:0] i_s0,
   input  logic [31:0] i_s1,
   input  logic [31:0] i_s2,
   output logic [31:0] o_s0,
   output logic [31:0] o_s1,
   output logic [31:0] o_s2,
   output logic [31:0] o_out
);

   assign o_s0  = ((i_s0 & TAUS_MASK0) << 12) ^ (((i_s0 << 13) ^ i_s0) >> 19);
   assign o_s1  = ((i_s1 & TAUS_MASK1) << 4)  ^ (((i_s1 << 2)  ^ i_s1) >> 25);
   assign o_s2  = ((i_s2 & TAUS_MASK2) << 17) ^ (((i_s2 << 3)  ^ i_s2) >> 11);
   assign o_out = o_s0 ^ o_s1 ^ o_s2;

endmodule

// File: rtl/taus_stream_checker.sv
// rtl/taus_stream_checker.sv - regenerates the taus88 sequence from the seed and
// checks every accepted uniform sample, reporting lock, errors and counters.
module taus_stream_checker
   import taus_stream_checker_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int LOCK_N    = 8,
   parameter int ERR_LIMIT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [31:0]          i_seed,
   input  logic                 i_start,
   taus_stream_checker_if.slave s_if,
   output logic                 o_seed_bad,
   output logic                 o_locked,
   output logic                 o_err_pulse,
   output logic                 o_fail,
   output logic [CNT_W-1:0]     o_sample_count,
   output logic [CNT_W-1:0]     o_err_count
);

   localparam int STREAK_W = $clog2(LOCK_N + 1);
   localparam logic [STREAK_W-1:0] LOCK_V   = STREAK_W'(LOCK_N);
   localparam logic [STREAK_W-1:0] LOCK_M1  = STREAK_W'(LOCK_N - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    ERR_V    = CNT_W'(ERR_LIMIT);

   state_t              r_state;
   state_t              w_state_nx;
   logic [31:0]         r_s0, r_s1, r_s2;
   logic [STREAK_W-1:0] r_streak;
   logic                r_locked, r_err_pulse, r_fail, r_seed_bad;
   logic [CNT_W-1:0]    r_sample_count, r_err_count;

   logic [31:0] w_nx_s0, w_nx_s1, w_nx_s2, w_expected;
   logic [31:0] w_ld_s1, w_ld_s2;
   logic        w_ld_bad, w_ready, w_xfer, w_match;
   logic [CNT_W-1:0] w_err_inc;

   taus88_step u_step (
      .i_s0  (r_s0),
      .i_s1  (r_s1),
      .i_s2  (r_s2),
      .o_s0  (w_nx_s0),
      .o_s1  (w_nx_s1),
      .o_s2  (w_nx_s2),
      .o_out (w_expected)
   );

   assign w_ld_s1   = i_seed ^ TAUS_S1_XOR;
   assign w_ld_s2   = i_seed ^ TAUS_S2_XOR;
   assign w_ld_bad  = (i_seed < TAUS_MIN0) || (w_ld_s1 < TAUS_MIN1) || (w_ld_s2 < TAUS_MIN2);
   // start pre-empts a coincident sample: it is neither counted nor compared
   assign w_xfer    = s_if.in_valid && w_ready && !i_start;
   assign w_match   = (s_if.in_data == w_expected);
   assign w_err_inc = (r_err_count == CNT_MAX) ? r_err_count : r_err_count + 1'b1;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= ST_IDLE;
      else          r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_ready    = 1'b0;
      unique case (r_state)
         ST_IDLE: w_ready = 1'b0;
         ST_RUN:  w_ready = 1'b1;
         ST_BAD:  w_ready = 1'b0;
         default: w_ready = 1'b0;
      endcase
      if (i_start) w_state_nx = w_ld_bad ? ST_BAD : ST_RUN;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_s0 <= '0; r_s1 <= '0; r_s2 <= '0;
         r_streak <= '0; r_locked <= 1'b0; r_err_pulse <= 1'b0;
         r_fail <= 1'b0; r_seed_bad <= 1'b0;
         r_sample_count <= '0; r_err_count <= '0;
      end else begin
         r_err_pulse <= 1'b0;
         if (i_start) begin
            r_s0 <= i_seed; r_s1 <= w_ld_s1; r_s2 <= w_ld_s2;
            r_streak <= '0; r_locked <= 1'b0; r_fail <= 1'b0;
            r_seed_bad <= w_ld_bad;
            r_sample_count <= '0; r_err_count <= '0;
         end else if (w_xfer) begin
            r_s0 <= w_nx_s0; r_s1 <= w_nx_s1; r_s2 <= w_nx_s2;
            if (r_sample_count != CNT_MAX) r_sample_count <= r_sample_count + 1'b1;
            if (w_match) begin
               if (r_streak != LOCK_V) r_streak <= r_streak + 1'b1;
               if (r_streak >= LOCK_M1) r_locked <= 1'b1;
            end else begin
               r_err_pulse <= 1'b1;
               r_streak    <= '0;
               r_locked    <= 1'b0;
               r_err_count <= w_err_inc;
               if (w_err_inc >= ERR_V) r_fail <= 1'b1;
            end
         end
      end
   end

   assign s_if.in_ready   = w_ready;
   assign o_seed_bad      = r_seed_bad;
   assign o_locked        = r_locked;
   assign o_err_pulse     = r_err_pulse;
   assign o_fail          = r_fail;
   assign o_sample_count  = r_sample_count;
   assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_taus_stream_checker.sv
// tb/tb_taus_stream_checker.sv - scoreboard bench for taus_stream_checker
module tb_taus_stream_checker;

   typedef struct {
      logic        err;
      logic [15:0] cnt;
      logic [15:0] errc;
      logic        lk;
      logic        fl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] seed;
   logic        seed_bad, locked, err_pulse, fail;
   logic [15:0] sample_count, err_count;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        pending = 1'b0;

   logic [95:0] m_s;
   int          m_cnt, m_err, m_streak;
   logic        m_lock, m_fail;

   taus_stream_checker_if u_if ();

   taus_stream_checker #(.CNT_W(16), .LOCK_N(8), .ERR_LIMIT(4)) u_dut (
      .i_clk          (clk),
      .i_reset        (rst_n),
      .i_seed         (seed),
      .i_start        (start),
      .s_if           (u_if),
      .o_seed_bad     (seed_bad),
      .o_locked       (locked),
      .o_err_pulse    (err_pulse),
      .o_fail         (fail),
      .o_sample_count (sample_count),
      .o_err_count    (err_count)
   );

   always #5 clk = ~clk;

   // Golden taus88 step written straight from the recurrence
   function automatic logic [95:0] tb_step(input logic [95:0] st);
      logic [31:0] a, b, c;
      a = st[95:64]; b = st[63:32]; c = st[31:0];
      a = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
      b = ((b & 32'hFFFFFFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
      c = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
      return {a, b, c};
   endfunction

   function automatic logic [31:0] peek();
      logic [95:0] n;
      n = tb_step(m_s);
      return n[95:64] ^ n[63:32] ^ n[31:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] s);
      seed  = s;
      start = 1'b1;
      tick();
      start = 1'b0;
      m_s = {s, s ^ 32'h10850089, s ^ 32'h89305309};
      m_cnt = 0; m_err = 0; m_streak = 0; m_lock = 1'b0; m_fail = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic exp_err);
      exp_t e;
      m_s = tb_step(m_s);
      m_cnt++;
      if (exp_err) begin
         m_err++; m_streak = 0; m_lock = 1'b0;
         if (m_err >= 4) m_fail = 1'b1;
      end else begin
         if (m_streak < 8) m_streak++;
         if (m_streak == 8) m_lock = 1'b1;
      end
      e.err = exp_err; e.cnt = 16'(m_cnt); e.errc = 16'(m_err);
      e.lk = m_lock; e.fl = m_fail;
      sb_q.push_back(e);
      u_if.in_valid = 1'b1;
      u_if.in_data  = d;
      tick();
      u_if.in_valid = 1'b0;
   endtask

   // Monitor: checks the registered result one cycle after each accepted sample
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pending) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("err_pulse", {31'd0, err_pulse}, {31'd0, e.err});
               chk("sample_count", {16'd0, sample_count}, {16'd0, e.cnt});
               chk("err_count", {16'd0, err_count}, {16'd0, e.errc});
               chk("locked", {31'd0, locked}, {31'd0, e.lk});
               chk("fail", {31'd0, fail}, {31'd0, e.fl});
            end
         end
         pending = u_if.in_valid && u_if.in_ready && !start && rst_n;
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; seed = '0;
      u_if.in_valid = 1'b0; u_if.in_data = '0;
      m_s = '0; m_cnt = 0; m_err = 0; m_streak = 0; m_lock = 1'b0; m_fail = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("rst_ready", {31'd0, u_if.in_ready}, 32'd0);
      chk("rst_outs", {26'd0, seed_bad, locked, err_pulse, fail, |sample_count, |err_count}, 32'd0);

      // Good seed: hand-computed first sample, then golden run to lock
      do_start(32'hFFFFFFFF);
      chk("start_ready", {31'd0, u_if.in_ready}, 32'd1);
      chk("start_seed_bad", {31'd0, seed_bad}, 32'd0);
      send(32'h51A80170, 1'b0);
      for (int i = 0; i < 7; i++) send(peek(), 1'b0);
      tick();
      chk("lock_after_8", {31'd0, locked}, 32'd1);

      // Zero seed is below the taus88 minima
      do_start(32'h00000000);
      chk("bad_seed_bad", {31'd0, seed_bad}, 32'd1);
      chk("bad_ready", {31'd0, u_if.in_ready}, 32'd0);
      u_if.in_valid = 1'b1;
      repeat (3) tick();
      u_if.in_valid = 1'b0;
      tick();
      chk("bad_count", {16'd0, sample_count}, 32'd0);

      // Corrupt first sample, then golden samples keep matching
      do_start(32'hFFFFFFFF);
      chk("restart_seed_bad", {31'd0, seed_bad}, 32'd0);
      send(32'h51A80171, 1'b1);
      for (int i = 0; i < 8; i++) send(peek(), 1'b0);
      tick();
      chk("relock", {31'd0, locked}, 32'd1);
      chk("relock_errs", {16'd0, err_count}, 32'd1);

      // Locked run then a dropped sample: continuous errors until fail
      do_start(32'hFFFFFFFF);
      for (int i = 0; i < 8; i++) send(peek(), 1'b0);
      m_s = tb_step(m_s);
      for (int i = 0; i < 5; i++) send(peek(), 1'b1);
      tick();
      chk("drop_fail", {31'd0, fail}, 32'd1);
      chk("drop_errs", {16'd0, err_count}, 32'd5);
      do_start(32'hFFFFFFFF);
      chk("clr_fail", {31'd0, fail}, 32'd0);
      chk("clr_counts", {sample_count, err_count}, 32'd0);

      // start coinciding with a sample: start wins
      send(peek(), 1'b0);
      send(peek(), 1'b0);
      seed = 32'hFFFFFFFF; start = 1'b1;
      u_if.in_valid = 1'b1; u_if.in_data = 32'hDEADBEEF;
      chk("start_vs_valid_ready", {31'd0, u_if.in_ready}, 32'd1);
      tick();
      start = 1'b0; u_if.in_valid = 1'b0;
      m_s = {32'hFFFFFFFF, 32'hFFFFFFFF ^ 32'h10850089, 32'hFFFFFFFF ^ 32'h89305309};
      m_cnt = 0; m_err = 0; m_streak = 0; m_lock = 1'b0; m_fail = 1'b0;
      chk("start_vs_valid_count", {16'd0, sample_count}, 32'd0);
      send(32'h51A80170, 1'b0);
      send(peek(), 1'b0);
      send(32'h12345678, 1'b1);
      repeat (2) tick();

      // Asynchronous reset mid-run
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outs", {26'd0, seed_bad, locked, err_pulse, fail, |sample_count, |err_count}, 32'd0);
      chk("async_rst_ready", {31'd0, u_if.in_ready}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", {31'd0, u_if.in_ready}, 32'd0);
      do_start(32'hFFFFFFFF);
      send(32'h51A80170, 1'b0);
      send(peek(), 1'b0);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
      repeat (2) tick();
      if (sb_q.size() != 0) chk("sb_drain", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/taus_stream_checker.md
Name: taus_stream_checker

Overview:
- Receive-side checker for the combined three-component Tausworthe (taus88) uniform generator feeding the Box-Muller AWGN datapath.
- Seeded with the same 32-bit seed as the generator. Regenerates the expected uniform sequence locally and compares each accepted sample.
- Reports lock, per-sample mismatch pulses, and saturating sample/error counters.
- Sits on the uniform-sample bus between the URNG and the Box-Muller core, and doubles as a BIST monitor.

Parameters:
- CNT_W, 16, width of sample_count and err_count; both saturate at 2^CNT_W-1.
- LOCK_N, 8, consecutive matching samples required to assert locked.
- ERR_LIMIT, 4, err_count value at or above which fail asserts (sticky).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- seed  in  32  generator seed; sampled only on start.
- start  in  1  one-cycle pulse; loads seed and begins checking.
- in_valid  in  1  uniform sample present.
- in_data  in  32  uniform sample from generator.
- in_ready  out  1  checker accepts a sample this cycle.
- seed_bad  out  1  derived component state below taus88 minimum.
- locked  out  1  LOCK_N consecutive matches seen since the last mismatch.
- err_pulse  out  1  one-cycle pulse on a mismatched accepted sample.
- fail  out  1  sticky; set when err_count >= ERR_LIMIT.
- sample_count  out  CNT_W  accepted samples since start.
- err_count  out  CNT_W  mismatches since start.

Behaviour:
- Reset values: all outputs 0, state IDLE, s0/s1/s2 = 0.
- State machine: IDLE, RUN, BAD.
- Seed load:
  - start in any state loads s0=seed, s1=seed^0x10850089, s2=seed^0x89305309.
  - start also clears counters, the match streak, locked, fail and seed_bad.
  - If s0<2, s1<8 or s2<16, the next state is BAD with seed_bad=1. Otherwise the next state is RUN.
- States:
  - IDLE and BAD hold in_ready=0. They are left only by start.
  - RUN: in_ready=1. A transfer is in_valid && in_ready.
- On each transfer, step the local state in one cycle:
  - s0' = ((s0&0xFFFFFFFE)<<12) ^ (((s0<<13)^s0)>>19)
  - s1' = ((s1&0xFFFFFFF8)<<4) ^ (((s1<<2)^s1)>>25)
  - s2' = ((s2&0xFFFFFFF0)<<17) ^ (((s2<<3)^s2)>>11)
  - expected = s0'^s1'^s2'. The first sample after start is compared against the first stepped value, not the seed.
- Arithmetic: all 32-bit logical shifts; bits shifted out are discarded.
- Comparison (combinational on in_data vs expected; outputs registered, 1-cycle latency after the transfer):
  - Match: streak++ (saturating at LOCK_N); locked=1 when streak reaches LOCK_N.
  - Mismatch: err_pulse=1 for one cycle, err_count++ (saturating), streak=0, locked=0.
  - The local state always advances on a transfer, mismatch or not (no resync); a dropped or inserted sample therefore shows as a continuous error run.
- sample_count increments on every transfer and saturates.
- fail sets when err_count reaches ERR_LIMIT and stays set until start or reset.
- No transfer: state, counters and streak hold; err_pulse=0.
- start coinciding with in_valid in RUN: start wins, the sample is not compared, in_ready stays 1.
- Reset asserted mid-run: immediate return to the reset values; start is required to resume.

Decomposition:
- Shared package: taus88 constants (0x10850089, 0x89305309, masks 0xFFFFFFFE/0xFFFFFFF8/0xFFFFFFF0, minima 2/8/16) and the state enum.
- One sub-module, taus88_step: purely combinational next-state for (s0,s1,s2) plus the combined output. It is reusable by a future synthesizable generator rewrite.

Test Plan:
- reset=0 then 1, no start -> all outputs 0, in_ready=0.
- seed=0xFFFFFFFF, start, send in_data=0x51A80170 -> no err_pulse, sample_count=1. Then 7 more golden-model samples -> locked=1 after the 8th.
- seed=0x00000000, start -> seed_bad=1, state BAD, in_ready=0; in_valid pulses are ignored and sample_count stays 0.
- seed=0xFFFFFFFF, first sample 0x51A80171 -> err_pulse=1 one cycle later, err_count=1, locked=0. The following golden samples match, proving the local state advanced.
- Locked run, then drop one sample -> every subsequent sample mismatches; fail=1 when err_count=4; a new start clears fail and the counters.
- Mid-run, assert reset for 1 cycle -> outputs 0 asynchronously; start with the same seed -> first sample 0x51A80170 matches again.
